// File: rtl/dmem_pkg.sv
// Shared types and lane helpers for the sized data memory.
// Store byte enables and lane replication are computed here.
package dmem_pkg;

    typedef enum logic [1:0] {
        SZ_B   = 2'b00,
        SZ_H   = 2'b01,
        SZ_W   = 2'b10,
        SZ_BAD = 2'b11
    } size_e;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        WAIT = 2'b01,
        RESP = 2'b10
    } state_e;

    function automatic logic [3:0] byte_en(input size_e sz, input logic [1:0] off);
        case (sz)
            SZ_B:    byte_en = 4'b0001 << off;
            SZ_H:    byte_en = off[1] ? 4'b1100 : 4'b0011;
            SZ_W:    byte_en = 4'b1111;
            default: byte_en = 4'b0000;
        endcase
    endfunction

    // Replicate right-aligned store data so every lane sees its own byte.
    function automatic logic [31:0] lane_data(input size_e sz, input logic [31:0] wd);
        case (sz)
            SZ_B:    lane_data = {4{wd[7:0]}};
            SZ_H:    lane_data = {2{wd[15:0]}};
            default: lane_data = wd;
        endcase
    endfunction

endpackage

// File: rtl/dmem_load_align.sv
// Picks the addressed byte/half out of a memory word and extends it to 32 bits.
module dmem_load_align
    import dmem_pkg::*;
(
    input  logic [31:0] i_word,
    input  logic [1:0]  i_size,
    input  logic [1:0]  i_off,
    input  logic        i_unsigned,
    output logic [31:0] o_data
);

    logic [7:0]  w_byte;
    logic [15:0] w_half;

    always_comb begin
        w_byte = i_word[{i_off, 3'b000} +: 8];
        w_half = i_off[1] ? i_word[31:16] : i_word[15:0];
        case (size_e'(i_size))
            SZ_B:    o_data = {{24{w_byte[7] & ~i_unsigned}}, w_byte};
            SZ_H:    o_data = {{16{w_half[15] & ~i_unsigned}}, w_half};
            default: o_data = i_word;
        endcase
    end

endmodule

// File: rtl/dmem_sized.sv
// Single-outstanding data memory with byte/half/word access and configurable load latency.
// Memory is split into four byte-lane arrays so stores map onto byte-enabled block RAM.
module dmem_sized
    import dmem_pkg::*;
#(
    parameter int DEPTH_WORDS = 1024,
    parameter int ADDR_W      = 32,
    parameter int READ_LAT    = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [1:0]        req_size,
    input  logic              req_unsigned,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [31:0]       req_wdata,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [31:0]       rsp_rdata,
    output logic              rsp_err
);

    localparam int IDX_W = $clog2(DEPTH_WORDS);
    localparam int CNT_W = $clog2(READ_LAT + 1);
    localparam logic [CNT_W-1:0] CNT_RELOAD = CNT_W'(READ_LAT - 1);

    state_e           r_state;
    logic [CNT_W-1:0] r_cnt;
    logic             r_rsp_valid;
    logic             r_err;
    logic             r_load_ok;
    size_e            r_size;
    logic [1:0]       r_off;
    logic             r_unsigned;

    size_e             w_size;
    logic [ADDR_W-3:0] w_word_idx;
    logic [IDX_W-1:0]  w_idx;
    logic              w_range_err;
    logic              w_align_err;
    logic              w_err;
    logic              w_accept;
    logic              w_wr;
    logic [3:0]        w_be;
    logic [31:0]       w_lane_wdata;
    logic [31:0]       w_raw;
    logic [31:0]       w_aligned;

    assign w_size       = size_e'(req_size);
    assign w_word_idx   = req_addr[ADDR_W-1:2];
    assign w_idx        = req_addr[IDX_W+1:2];
    assign w_range_err  = {2'b00, w_word_idx} >= ADDR_W'(DEPTH_WORDS);
    assign w_align_err  = (w_size == SZ_H && req_addr[0]) ||
                          (w_size == SZ_W && req_addr[1:0] != 2'b00);
    assign w_err        = (w_size == SZ_BAD) || w_align_err || w_range_err;
    assign w_accept     = req_valid && req_ready;
    assign w_wr         = w_accept && req_we && !w_err;
    assign w_be         = byte_en(w_size, req_addr[1:0]);
    assign w_lane_wdata = lane_data(w_size, req_wdata);

    // Read and write both happen on the accept edge; the read port is read-first.
    for (genvar gi = 0; gi < 4; gi++) begin : g_lane
        logic [7:0] r_mem [DEPTH_WORDS];
        logic [7:0] r_rd;

        always_ff @(posedge clk) begin
            if (w_wr && w_be[gi]) begin
                r_mem[w_idx] <= w_lane_wdata[gi*8 +: 8];
            end
            if (w_accept) begin
                r_rd <= r_mem[w_idx];
            end
        end

        assign w_raw[gi*8 +: 8] = r_rd;
    end

    dmem_load_align u_align (
        .i_word     (w_raw),
        .i_size     (r_size),
        .i_off      (r_off),
        .i_unsigned (r_unsigned),
        .o_data     (w_aligned)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= IDLE;
            r_cnt       <= '0;
            r_rsp_valid <= 1'b0;
            r_err       <= 1'b0;
            r_load_ok   <= 1'b0;
            r_size      <= SZ_W;
            r_off       <= 2'b00;
            r_unsigned  <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        r_err      <= w_err;
                        r_load_ok  <= !req_we && !w_err;
                        r_size     <= w_size;
                        r_off      <= req_addr[1:0];
                        r_unsigned <= req_unsigned;
                        if (!req_we && !w_err && READ_LAT > 1) begin
                            r_state <= WAIT;
                            r_cnt   <= CNT_RELOAD;
                        end else begin
                            r_state     <= RESP;
                            r_rsp_valid <= 1'b1;
                        end
                    end
                end
                WAIT: begin
                    if (r_cnt <= CNT_W'(1)) begin
                        r_state     <= RESP;
                        r_rsp_valid <= 1'b1;
                        r_cnt       <= '0;
                    end else begin
                        r_cnt <= r_cnt - 1'b1;
                    end
                end
                RESP: begin
                    if (rsp_ready) begin
                        r_state     <= IDLE;
                        r_rsp_valid <= 1'b0;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign req_ready = (r_state == IDLE);
    assign rsp_valid = r_rsp_valid;
    assign rsp_err   = r_err;
    assign rsp_rdata = r_load_ok ? w_aligned : 32'h0;

endmodule

// File: tb/tb_dmem_sized.sv
// Scoreboard bench for dmem_sized: a byte-level model and directed constants feed an
// expectation queue that is drained as responses appear.
module tb_dmem_sized;

    localparam int LAT = 3;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_we = 1'b0;
    logic [1:0]  req_size = 2'b00;
    logic        req_unsigned = 1'b0;
    logic [31:0] req_addr = 32'h0;
    logic [31:0] req_wdata = 32'h0;
    logic        rsp_ready = 1'b1;
    logic        req_ready;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        rsp_err;

    int n_cmp = 0;
    int n_bad = 0;

    typedef struct {
        logic [31:0] data;
        logic        err;
        int          lat;
    } exp_t;

    exp_t       exp_q[$];
    logic [7:0] mm [4096];

    always #5 clk = ~clk;

    dmem_sized #(
        .DEPTH_WORDS (1024),
        .ADDR_W      (32),
        .READ_LAT    (LAT)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_we       (req_we),
        .req_size     (req_size),
        .req_unsigned (req_unsigned),
        .req_addr     (req_addr),
        .req_wdata    (req_wdata),
        .rsp_valid    (rsp_valid),
        .rsp_ready    (rsp_ready),
        .rsp_rdata    (rsp_rdata),
        .rsp_err      (rsp_err)
    );

    task automatic model(input logic we, input logic [1:0] sz, input logic uns,
                         input logic [31:0] a, input logic [31:0] wd,
                         output logic [31:0] d, output logic e);
        logic [11:0] b;
        b = a[11:0];
        d = 32'h0;
        e = (sz == 2'b11) || (sz == 2'b01 && a[0]) ||
            (sz == 2'b10 && a[1:0] != 2'b00) || (a[31:2] >= 30'd1024);
        if (!e) begin
            if (we) begin
                mm[b] = wd[7:0];
                if (sz != 2'b00) mm[b+12'd1] = wd[15:8];
                if (sz == 2'b10) begin
                    mm[b+12'd2] = wd[23:16];
                    mm[b+12'd3] = wd[31:24];
                end
            end else begin
                case (sz)
                    2'b00:   d = {{24{mm[b][7] & ~uns}}, mm[b]};
                    2'b01:   d = {{16{mm[b+12'd1][7] & ~uns}}, mm[b+12'd1], mm[b]};
                    default: d = {mm[b+12'd3], mm[b+12'd2], mm[b+12'd1], mm[b]};
                endcase
            end
        end
    endtask

    // One full transaction: push expectation, drive, wait for response, check, handshake.
    task automatic xact(input string nm, input logic we, input logic [1:0] sz, input logic uns,
                        input logic [31:0] a, input logic [31:0] wd, input int hold,
                        input logic use_const, input logic [31:0] cd, input logic ce);
        exp_t        ex;
        exp_t        got;
        int          n;
        logic [31:0] md;
        logic        me;
        model(we, sz, uns, a, wd, md, me);
        ex.data = use_const ? cd : md;
        ex.err  = use_const ? ce : me;
        ex.lat  = (!we && !ex.err) ? LAT : 1;
        exp_q.push_back(ex);

        @(negedge clk);
        req_valid = 1'b1; req_we = we; req_size = sz; req_unsigned = uns;
        req_addr = a; req_wdata = wd; rsp_ready = (hold == 0);
        n = 0;
        while (!req_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        @(posedge clk);
        #1;
        req_valid = 1'b0; req_addr = $urandom(); req_wdata = $urandom(); req_we = $urandom_range(0, 1);

        n = 1;
        @(negedge clk);
        while (!rsp_valid && n < 50) begin
            @(negedge clk);
            n++;
        end
        got = exp_q.pop_front();
        n_cmp++;
        if (n != got.lat) begin
            n_bad++;
            $display("FAIL %s latency: got %0d edges, expected %0d", nm, n, got.lat);
        end
        n_cmp++;
        if (rsp_rdata !== got.data) begin
            n_bad++;
            $display("FAIL %s rdata: got %h, expected %h", nm, rsp_rdata, got.data);
        end
        n_cmp++;
        if (rsp_err !== got.err) begin
            n_bad++;
            $display("FAIL %s err: got %b, expected %b", nm, rsp_err, got.err);
        end
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            n_cmp++;
            if (rsp_valid !== 1'b1 || rsp_rdata !== got.data || rsp_err !== got.err || req_ready !== 1'b0) begin
                n_bad++;
                $display("FAIL %s hold%0d: got valid=%b rdata=%h err=%b ready=%b, expected 1/%h/%b/0",
                         nm, i, rsp_valid, rsp_rdata, rsp_err, req_ready, got.data, got.err);
            end
        end
        rsp_ready = 1'b1;
        @(negedge clk);
        n_cmp++;
        if (rsp_valid !== 1'b0 || req_ready !== 1'b1) begin
            n_bad++;
            $display("FAIL %s release: got valid=%b ready=%b, expected 0/1", nm, rsp_valid, req_ready);
        end
        $display("xact %-10s we=%0b sz=%0d uns=%0b addr=%h wdata=%h -> rdata=%h err=%0b lat=%0d",
                 nm, we, sz, uns, a, wd, got.data, got.err, n);
    endtask

    task automatic test_reset();
        repeat (3) @(posedge clk);
        @(negedge clk);
        n_cmp++;
        if (rsp_valid !== 1'b0 || rsp_err !== 1'b0 || rsp_rdata !== 32'h0) begin
            n_bad++;
            $display("FAIL reset_outputs: got valid=%b err=%b rdata=%h, expected 0/0/0", rsp_valid, rsp_err, rsp_rdata);
        end
        rst_n = 1'b1;
        @(negedge clk);
        n_cmp++;
        if (req_ready !== 1'b1 || rsp_valid !== 1'b0) begin
            n_bad++;
            $display("FAIL reset_release: got ready=%b valid=%b, expected 1/0", req_ready, rsp_valid);
        end
    endtask

    task automatic test_async_reset();
        @(negedge clk);
        req_valid = 1'b1; req_we = 1'b0; req_size = 2'b11; req_addr = 32'd8; rsp_ready = 1'b0;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        n_cmp++;
        if (rsp_valid !== 1'b1 || rsp_err !== 1'b1) begin
            n_bad++;
            $display("FAIL async_pre: got valid=%b err=%b, expected 1/1", rsp_valid, rsp_err);
        end
        #2 rst_n = 1'b0;
        #1;
        n_cmp++;
        if (rsp_valid !== 1'b0 || rsp_err !== 1'b0 || rsp_rdata !== 32'h0 || req_ready !== 1'b1) begin
            n_bad++;
            $display("FAIL async_reset: got valid=%b err=%b rdata=%h ready=%b, expected 0/0/0/1",
                     rsp_valid, rsp_err, rsp_rdata, req_ready);
        end
        @(negedge clk);
        rst_n = 1'b1;
        rsp_ready = 1'b1;
        @(negedge clk);
        n_cmp++;
        if (req_ready !== 1'b1 || rsp_valid !== 1'b0) begin
            n_bad++;
            $display("FAIL async_release: got ready=%b valid=%b, expected 1/0", req_ready, rsp_valid);
        end
    endtask

    task automatic test_store_load();
        xact("sw8", 1'b1, 2'b10, 1'b0, 32'd8, 32'hAABBCCDD, 0, 1'b1, 32'h0, 1'b0);
        xact("lw8", 1'b0, 2'b10, 1'b0, 32'd8, 32'h0, 0, 1'b1, 32'hAABBCCDD, 1'b0);
    endtask

    task automatic test_lanes();
        xact("sw12", 1'b1, 2'b10, 1'b0, 32'd12, 32'h12345678, 0, 1'b1, 32'h0, 1'b0);
        xact("sb13", 1'b1, 2'b00, 1'b0, 32'd13, 32'h00000080, 0, 1'b1, 32'h0, 1'b0);
        xact("lw12", 1'b0, 2'b10, 1'b0, 32'd12, 32'h0, 0, 1'b1, 32'h12348078, 1'b0);
        xact("lb13", 1'b0, 2'b00, 1'b0, 32'd13, 32'h0, 0, 1'b1, 32'hFFFFFF80, 1'b0);
        xact("lbu13", 1'b0, 2'b00, 1'b1, 32'd13, 32'h0, 0, 1'b1, 32'h00000080, 1'b0);
    endtask

    task automatic test_boundary();
        xact("sw4092", 1'b1, 2'b10, 1'b0, 32'd4092, 32'hFFFFFFFF, 0, 1'b1, 32'h0, 1'b0);
        xact("lw4092", 1'b0, 2'b10, 1'b0, 32'd4092, 32'h0, 0, 1'b1, 32'hFFFFFFFF, 1'b0);
        xact("lh4094", 1'b0, 2'b01, 1'b0, 32'd4094, 32'h0, 0, 1'b1, 32'hFFFFFFFF, 1'b0);
        xact("lhu4094", 1'b0, 2'b01, 1'b1, 32'd4094, 32'h0, 0, 1'b1, 32'h0000FFFF, 1'b0);
        xact("sw5000", 1'b1, 2'b10, 1'b0, 32'd5000, 32'h0, 0, 1'b1, 32'h0, 1'b1);
        xact("lw4092b", 1'b0, 2'b10, 1'b0, 32'd4092, 32'h0, 0, 1'b1, 32'hFFFFFFFF, 1'b0);
    endtask

    task automatic test_errors();
        xact("lw10", 1'b0, 2'b10, 1'b0, 32'd10, 32'h0, 0, 1'b1, 32'h0, 1'b1);
        xact("lh13", 1'b0, 2'b01, 1'b0, 32'd13, 32'h0, 0, 1'b1, 32'h0, 1'b1);
        xact("bad8", 1'b1, 2'b11, 1'b0, 32'd8, 32'h11223344, 0, 1'b1, 32'h0, 1'b1);
        xact("lw8chk", 1'b0, 2'b10, 1'b0, 32'd8, 32'h0, 0, 1'b1, 32'hAABBCCDD, 1'b0);
    endtask

    task automatic test_backpressure();
        xact("lw12hold", 1'b0, 2'b10, 1'b0, 32'd12, 32'h0, 3, 1'b1, 32'h12348078, 1'b0);
        xact("swhold", 1'b1, 2'b01, 1'b0, 32'd20, 32'h0000BEEF, 3, 1'b1, 32'h0, 1'b0);
    endtask

    task automatic test_reset_wait();
        int seen;
        @(negedge clk);
        req_valid = 1'b1; req_we = 1'b0; req_size = 2'b10; req_addr = 32'd8; rsp_ready = 1'b1;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        @(negedge clk);
        #1 rst_n = 1'b0;
        #1;
        n_cmp++;
        if (rsp_valid !== 1'b0 || req_ready !== 1'b1) begin
            n_bad++;
            $display("FAIL wait_reset: got valid=%b ready=%b, expected 0/1", rsp_valid, req_ready);
        end
        @(negedge clk);
        rst_n = 1'b1;
        seen = 0;
        for (int i = 0; i < LAT + 2; i++) begin
            @(negedge clk);
            if (rsp_valid !== 1'b0 || req_ready !== 1'b1) seen++;
        end
        n_cmp++;
        if (seen != 0) begin
            n_bad++;
            $display("FAIL wait_dropped: got %0d cycles with stale response, expected 0", seen);
        end
        xact("lw8post", 1'b0, 2'b10, 1'b0, 32'd8, 32'h0, 0, 1'b1, 32'hAABBCCDD, 1'b0);
    endtask

    task automatic test_back_to_back();
        logic [1:0]  sz;
        logic [31:0] a;
        for (int w = 0; w < 16; w++) begin
            xact("fill", 1'b1, 2'b10, 1'b0, 32'(w * 4), $urandom(), 0, 1'b0, 32'h0, 1'b0);
        end
        for (int k = 0; k < 40; k++) begin
            sz = 2'($urandom_range(0, 3));
            a  = ($urandom_range(0, 7) == 0) ? 32'($urandom_range(4092, 4200)) : 32'($urandom_range(0, 63));
            xact("rand", 1'($urandom_range(0, 1)), sz, 1'($urandom_range(0, 1)), a, $urandom(),
                 $urandom_range(0, 2), 1'b0, 32'h0, 1'b0);
        end
    endtask

    initial begin
        for (int i = 0; i < 4096; i++) mm[i] = 8'h00;
        test_reset();
        test_async_reset();
        test_store_load();
        test_lanes();
        test_boundary();
        test_errors();
        test_backpressure();
        test_reset_wait();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/dmem_sized.md
DMEM_SIZED -- requirements
Module: dmem_sized

Interface
REQ-001 SHALL have parameter DEPTH_WORDS, default 1024, number of 32-bit words (power of two, >=4).
REQ-002 SHALL have parameter ADDR_W, default 32, byte-address width.
REQ-003 SHALL have parameter READ_LAT, default 1, load latency in clock edges (legal range 1..4).
REQ-004 clk  in  1  single clock; all state changes on its rising edge.
REQ-005 rst_n  in  1  reset, asynchronous assert, active-low.
REQ-006 req_valid  in  1  request present.
REQ-007 req_ready  out  1  block can accept a request.
REQ-008 req_we  in  1  1 = store, 0 = load.
REQ-009 req_size  in  2  00 byte, 01 half, 10 word, 11 illegal.
REQ-010 req_unsigned  in  1  loads only: zero-extend (1) or sign-extend (0).
REQ-011 req_addr  in  ADDR_W  byte address, little-endian lanes.
REQ-012 req_wdata  in  32  store data, right-aligned (byte in [7:0], half in [15:0]).
REQ-013 rsp_valid  out  1  response present.
REQ-014 rsp_ready  in  1  consumer accepts response.
REQ-015 rsp_rdata  out  32  load data, extended; 0 for stores and errors.
REQ-016 rsp_err  out  1  misaligned, out-of-range or illegal size.

Function
REQ-017 Accept SHALL occur on an edge with req_valid && req_ready; req_ready SHALL be 1 only in state IDLE.
REQ-018 FSM states IDLE, WAIT, RESP; IDLE->RESP on accepted store, error, or load with READ_LAT=1; IDLE->WAIT on accepted valid load with READ_LAT>1; WAIT->RESP when latency counter expires; RESP->IDLE on rsp_valid && rsp_ready.
REQ-019 rsp_valid SHALL be 1 exactly in RESP: READ_LAT edges after accept for valid loads, 1 edge after accept for stores and errors.
REQ-020 Error SHALL be flagged when: size 11; half with addr[0]=1; word with addr[1:0]!=0; word index addr[ADDR_W-1:2] >= DEPTH_WORDS.
REQ-021 Errored requests SHALL NOT modify memory; response rsp_err=1, rsp_rdata=0.
REQ-022 Valid stores SHALL write only selected byte lanes (byte: lane addr[1:0]; half: lanes addr[1]*2+{0,1}; word: all) on the accept edge; response rsp_err=0, rsp_rdata=0.
REQ-023 Valid loads SHALL extract the addressed lane(s), then sign- or zero-extend to 32 bits per req_unsigned; word loads ignore req_unsigned.
REQ-024 Load data SHALL be sampled from memory on the accept edge; a load issued after a store to the same word returns the stored data.
REQ-025 rsp_rdata and rsp_err SHALL be held stable while rsp_valid=1 and rsp_ready=0.
REQ-026 Request inputs outside an accept edge SHALL be ignored; no request queuing (one outstanding).
REQ-027 Outputs SHALL never be high-impedance.

Reset
REQ-028 rst_n=0 SHALL force state IDLE, latency counter 0, rsp_valid=0, rsp_err=0, rsp_rdata=0, req_ready=1 (after release) immediately, irrespective of clk.
REQ-029 Reset mid-operation SHALL drop the pending response; stores already accepted remain written.
REQ-030 Memory array SHALL NOT be cleared by reset; simulation initialises it to 0.

Structure
REQ-031 Package dmem_pkg SHALL hold the size enum (SZ_B, SZ_H, SZ_W, SZ_BAD), FSM state enum, and byte-enable generation function.
REQ-032 Sub-module dmem_load_align (combinational lane extract + extension) SHALL be instantiated once.
REQ-033 Latency counter width SHALL be $clog2(READ_LAT+1).

Verification
REQ-034 SW 0xAABBCCDD @8, then LW @8 -> rsp_rdata=0xAABBCCDD, rsp_err=0, rsp_valid READ_LAT edges after accept.
REQ-035 SW 0x12345678 @12, SB 0x80 @13 -> LW @12=0x12348078; LB @13=0xFFFFFF80; LBU @13=0x00000080.
REQ-036 SW 0xFFFFFFFF @4092 -> LW=0xFFFFFFFF; LH @4094=0xFFFFFFFF; LHU @4094=0x0000FFFF; SW @5000 -> rsp_err=1, LW @4092 unchanged.
REQ-037 LW @10, LH @13, size 11 @8 -> each rsp_err=1, rsp_rdata=0, memory @8 unchanged.
REQ-038 rsp_ready=0 for 3 cycles -> rsp_valid, rsp_rdata stable, req_ready=0; after handshake req_ready=1 next cycle.
REQ-039 READ_LAT=3, rst_n low during WAIT -> rsp_valid=0 at once, req_ready=1 after release, LW @8 still 0xAABBCCDD.
